// File: rtl/decoder_2_4_strobe.sv
// decoder_2_4_strobe: registered 2-to-4 one-hot decoder with valid/ready input and programmable hold time.
// Ports: clk, reset (sync, active-low), in_valid/in_ready/index (input handshake),
//        result (one-hot), out_valid, busy (in HOLD), wrap (3->0 code pulse).
// Optional: define DECODER_WRAP_FLAG_EN to build the wrap register and last_index compare.
module decoder_2_4_strobe #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] index,
  output logic [3:0] result,
  output logic       out_valid,
  output logic       busy,
  output logic       wrap
);
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [3:0] CNT_LOAD = 4'(HOLD_CYCLES - 1);
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] result_q, result_d;
  logic       out_valid_q, out_valid_d;
  logic       accept;
  assign in_ready  = reset & ((state_q == IDLE) | (cnt_q == 4'd0));
  assign accept    = in_valid & in_ready;
  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == HOLD);
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      state_d     = HOLD;
      cnt_d       = CNT_LOAD;
      result_d    = 4'b0001 << index;
      out_valid_d = 1'b1;
    end else if (state_q == HOLD && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else if (state_q == HOLD) begin
      state_d     = IDLE;
      result_d    = 4'd0;
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      result_q    <= 4'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end
`ifdef DECODER_WRAP_FLAG_EN
  logic [1:0] last_index_q, last_index_d;
  logic       wrap_q, wrap_d;
  // last_index resets to 0, so the first accept after reset can never look like 3->0.
  always_comb begin
    last_index_d = accept ? index : last_index_q;
    wrap_d       = accept & (index == 2'd0) & (last_index_q == 2'd3);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_index_q <= 2'd0;
      wrap_q       <= 1'b0;
    end else begin
      last_index_q <= last_index_d;
      wrap_q       <= wrap_d;
    end
  end
  assign wrap = wrap_q;
`else
  assign wrap = 1'b0;
`endif
endmodule
